// File: rtl/gpio_cond_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
package gpio_cond_pkg;

   localparam int unsigned DEFAULT_DEBOUNCE = 25000;  // 1 ms at 25 MHz

   // A programmed limit of zero behaves exactly like a limit of one.
   function automatic int unsigned eff_limit(input int unsigned limit);
      return (limit == 0) ? 1 : limit;
   endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One conditioned input bit: two-flop synchronizer, debounce counter, clean level
// and single-cycle edge pulses.
module gpio_debounce_bit
   import gpio_cond_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             raw_in,
   input  logic [CNT_W-1:0] debounce_limit,
   output logic             clean,
   output logic             rise_pulse,
   output logic             fall_pulse
);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last_cnt_c;

   // Count value at which the level is accepted; >= lets a lowered limit act at once.
   always_comb last_cnt_c = CNT_W'(eff_limit(32'(debounce_limit)) - 32'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1      <= RESET_VAL;
         sync2      <= RESET_VAL;
         clean      <= RESET_VAL;
         cnt        <= '0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         sync1      <= raw_in;
         sync2      <= sync1;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         if (sync2 == clean) begin
            cnt <= '0;
         end else if (cnt >= last_cnt_c) begin
            clean      <= sync2;
            cnt        <= '0;
            rise_pulse <= sync2;
            fall_pulse <= ~sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions asynchronous board inputs for CoreGPIO GPIO_IN and produces edge
// pulses plus an aggregate event for fabric interrupts.
module gpio_in_conditioner
   import gpio_cond_pkg::*;
#(
   parameter int unsigned           WIDTH     = 2,
   parameter int unsigned           CNT_W     = 16,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             PCLK,
   input  logic             PRESETN,
   input  logic [WIDTH-1:0] RAW_IN,
   input  logic [CNT_W-1:0] DEBOUNCE_LIMIT,
   output logic [WIDTH-1:0] GPIO_IN_CLEAN,
   output logic [WIDTH-1:0] RISE_PULSE,
   output logic [WIDTH-1:0] FALL_PULSE,
   output logic             EVENT
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_debounce_bit #(
         .CNT_W     (CNT_W),
         .RESET_VAL (RESET_VAL[i])
      ) u_bit (
         .clk            (PCLK),
         .rst_n          (PRESETN),
         .raw_in         (RAW_IN[i]),
         .debounce_limit (DEBOUNCE_LIMIT),
         .clean          (GPIO_IN_CLEAN[i]),
         .rise_pulse     (RISE_PULSE[i]),
         .fall_pulse     (FALL_PULSE[i])
      );
   end

   // Aggregate event trails the pulses by one cycle.
   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         EVENT <= 1'b0;
      end else begin
         EVENT <= |{RISE_PULSE, FALL_PULSE};
      end
   end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner: directed scenarios plus random
// toggling, checked against a run-length reference model.
module tb_gpio_in_conditioner;

   logic        PCLK = 1'b0;
   logic        PRESETN;
   logic [1:0]  RAW_IN;
   logic [15:0] DEBOUNCE_LIMIT;
   logic [1:0]  GPIO_IN_CLEAN;
   logic [1:0]  RISE_PULSE;
   logic [1:0]  FALL_PULSE;
   logic        EVENT;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
   logic       m_event;
   int         run [2];
   int         obs_r [2];
   int         obs_f [2];

   gpio_in_conditioner #(.WIDTH(2), .CNT_W(16), .RESET_VAL(2'b00)) dut (
      .PCLK           (PCLK),
      .PRESETN        (PRESETN),
      .RAW_IN         (RAW_IN),
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .GPIO_IN_CLEAN  (GPIO_IN_CLEAN),
      .RISE_PULSE     (RISE_PULSE),
      .FALL_PULSE     (FALL_PULSE),
      .EVENT          (EVENT)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge: advance the model using the pre-edge inputs, then compare.
   task automatic step();
      int lim;
      @(posedge PCLK);
      if (!PRESETN) begin
         m_s1 = 2'b00; m_s2 = 2'b00; m_clean = 2'b00;
         m_rise = 2'b00; m_fall = 2'b00; m_event = 1'b0;
         run[0] = 0; run[1] = 0;
      end else begin
         m_event = |{m_rise, m_fall};
         lim = (DEBOUNCE_LIMIT == 16'd0) ? 1 : int'(DEBOUNCE_LIMIT);
         m_rise = 2'b00; m_fall = 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != m_clean[i]) begin
               run[i]++;
               if (run[i] >= lim) begin
                  m_clean[i] = m_s2[i];
                  m_rise[i]  = m_s2[i];
                  m_fall[i]  = ~m_s2[i];
                  run[i]     = 0;
               end
            end else begin
               run[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = RAW_IN;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         obs_r[i] += int'(RISE_PULSE[i]);
         obs_f[i] += int'(FALL_PULSE[i]);
      end
      chk("clean", 32'(GPIO_IN_CLEAN), 32'(m_clean));
      chk("rise",  32'(RISE_PULSE),    32'(m_rise));
      chk("fall",  32'(FALL_PULSE),    32'(m_fall));
      chk("event", 32'(EVENT),         32'(m_event));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int r0, f0, r1, f1;
      m_rise = '0; m_fall = '0; m_event = 1'b0;
      m_s1 = '0; m_s2 = '0; m_clean = '0;
      run[0] = 0; run[1] = 0;
      obs_r[0] = 0; obs_r[1] = 0; obs_f[0] = 0; obs_f[1] = 0;

      // Reset with inputs high, then release: clean rises 6 edges later
      PRESETN = 1'b0; RAW_IN = 2'b11; DEBOUNCE_LIMIT = 16'd4;
      steps(3);
      chk("rst_clean", 32'(GPIO_IN_CLEAN), 32'h0);
      PRESETN = 1'b1;
      steps(5);
      chk("rel_clean5", 32'(GPIO_IN_CLEAN), 32'h0);
      step();
      chk("rel_clean6", 32'(GPIO_IN_CLEAN), 32'h3);
      chk("rel_rise6",  32'(RISE_PULSE),    32'h3);
      step();
      chk("rel_event7", 32'(EVENT),         32'h1);
      chk("rel_rise7",  32'(RISE_PULSE),    32'h0);

      // Latency at L=4
      RAW_IN = 2'b00;
      steps(8);
      RAW_IN = 2'b01;
      steps(5);
      chk("lat_clean5", 32'(GPIO_IN_CLEAN[0]), 32'h0);
      step();
      chk("lat_clean6", 32'(GPIO_IN_CLEAN[0]), 32'h1);
      chk("lat_rise6",  32'(RISE_PULSE[0]),    32'h1);
      step();
      chk("lat_rise7",  32'(RISE_PULSE[0]),    32'h0);
      chk("lat_event7", 32'(EVENT),            32'h1);
      steps(3);

      // Glitch rejection on bit 1, then real rise and fall
      r1 = obs_r[1]; f1 = obs_f[1];
      RAW_IN = 2'b11; steps(3);
      RAW_IN = 2'b01; steps(10);
      chk("glitch_rise", 32'(obs_r[1] - r1), 32'h0);
      chk("glitch_fall", 32'(obs_f[1] - f1), 32'h0);
      RAW_IN = 2'b11; steps(8);
      chk("hold_rise", 32'(obs_r[1] - r1), 32'h1);
      RAW_IN = 2'b01; steps(8);
      chk("hold_fall", 32'(obs_f[1] - f1), 32'h1);

      // Limit zero behaves as one: 3-edge latency, 1-cycle glitch passes
      DEBOUNCE_LIMIT = 16'd0;
      RAW_IN = 2'b00;
      steps(2);
      chk("l0_clean2", 32'(GPIO_IN_CLEAN[0]), 32'h1);
      step();
      chk("l0_clean3", 32'(GPIO_IN_CLEAN[0]), 32'h0);
      chk("l0_fall3",  32'(FALL_PULSE[0]),    32'h1);
      steps(3);
      r1 = obs_r[1]; f1 = obs_f[1];
      RAW_IN = 2'b10; step();
      RAW_IN = 2'b00; steps(8);
      chk("l0_glitch_rise", 32'(obs_r[1] - r1), 32'h1);
      chk("l0_glitch_fall", 32'(obs_f[1] - f1), 32'h1);

      // Mid-count limit reduction: count 50 of 100, limit drops to 10
      DEBOUNCE_LIMIT = 16'd100;
      r0 = obs_r[0];
      RAW_IN = 2'b01;
      steps(52);
      chk("mid_pre_rise", 32'(obs_r[0] - r0), 32'h0);
      DEBOUNCE_LIMIT = 16'd10;
      step();
      chk("mid_rise",  32'(RISE_PULSE[0]),    32'h1);
      chk("mid_clean", 32'(GPIO_IN_CLEAN[0]), 32'h1);
      steps(3);

      // Reset mid-count discards the count; count restarts after release
      DEBOUNCE_LIMIT = 16'd2;
      RAW_IN = 2'b00; steps(8);
      DEBOUNCE_LIMIT = 16'd8;
      r0 = obs_r[0]; f0 = obs_f[0]; r1 = obs_r[1];
      RAW_IN = 2'b11; steps(5);
      PRESETN = 1'b0; step();
      chk("rstmid_clean", 32'(GPIO_IN_CLEAN), 32'h0);
      PRESETN = 1'b1;
      steps(9);
      chk("rstmid_nopulse", 32'(obs_r[0] - r0 + obs_f[0] - f0 + obs_r[1] - r1), 32'h0);
      chk("rstmid_clean9", 32'(GPIO_IN_CLEAN), 32'h0);
      step();
      chk("rstmid_clean10", 32'(GPIO_IN_CLEAN), 32'h3);
      chk("rstmid_rise10",  32'(RISE_PULSE),    32'h3);

      // Random toggling with varying limits and occasional resets
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) RAW_IN[$urandom_range(0, 1)] ^= 1'b1;
         if ($urandom_range(0, 99) == 0) DEBOUNCE_LIMIT = 16'($urandom_range(0, 6));
         PRESETN = ($urandom_range(0, 199) != 0);
         step();
      end
      PRESETN = 1'b1;
      steps(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
